// File: rtl/arbitro_rr_8vie.sv
// Round-robin arbiter for 8 requesters sharing one datapath: one-hot grant, alpha select,
// hold timeout and a guaranteed dead cycle between tenures.
module arbitro_rr_8vie #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic [7:0] fine,
    output logic [7:0] grant,
    output logic [2:0] alpha,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t        state, state_next;
    logic [2:0]    ptr, ptr_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    grant_next;
    logic [2:0]    alpha_next;
    logic          busy_next;
    logic          timeout_next;

    logic [2:0]    pick;
    logic          pick_valid;
    logic [2:0]    idx;
    logic          released;
    logic          abandoned;
    logic          hold_limit;

    // Scan requests starting at ptr so the previous winner gets the lowest priority.
    always_comb begin
        pick       = 3'd0;
        pick_valid = 1'b0;
        idx        = 3'd0;
        for (int o = 0; o < 8; o++) begin
            idx = ptr + 3'(o);
            if (req[idx] && !pick_valid) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // During a tenure alpha holds the index of the granted requester.
    assign released   = fine[alpha];
    assign abandoned  = ~req[alpha];
    assign hold_limit = (cnt == CW'(MAX_HOLD - 1));

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cnt_next     = cnt;
        grant_next   = grant;
        alpha_next   = alpha;
        busy_next    = busy;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = 8'd1 << pick;
                    alpha_next = pick;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (released || abandoned || hold_limit) begin
                    grant_next   = 8'd0;
                    busy_next    = 1'b0;
                    ptr_next     = alpha + 3'd1;
                    timeout_next = hold_limit && !released && !abandoned;
                    state_next   = RELEASE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RELEASE: begin
                grant_next = 8'd0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                grant_next = 8'd0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            cnt     <= '0;
            grant   <= 8'd0;
            alpha   <= 3'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            cnt     <= cnt_next;
            grant   <= grant_next;
            alpha   <= alpha_next;
            busy    <= busy_next;
            timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_arbitro_rr_8vie.sv
// Directed bench for arbitro_rr_8vie: a vector table of per-cycle inputs and expected
// outputs, plus hand-written reset, round-robin, timeout and simultaneous-end sequences.
module tb_arbitro_rr_8vie;

    logic       clock;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] fine;
    logic [7:0] grant;
    logic [2:0] alpha;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] fine;
        logic [7:0] grant;
        logic [2:0] alpha;
        logic       busy;
        logic       timeout;
    } vec_t;

    vec_t vecs [17];

    arbitro_rr_8vie #(.MAX_HOLD(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .fine    (fine),
        .grant   (grant),
        .alpha   (alpha),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] g, input logic [2:0] a,
                             input logic b, input logic t);
        check_output({name, ".grant"}, grant, g);
        check_output({name, ".alpha"}, {5'd0, alpha}, {5'd0, a});
        check_output({name, ".busy"}, {7'd0, busy}, {7'd0, b});
        check_output({name, ".timeout"}, {7'd0, timeout}, {7'd0, t});
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic apply_stimulus(input logic [7:0] r, input logic [7:0] f);
        req  = r;
        fine = f;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] r);
        req     = r;
        fine    = 8'd0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[1]  = '{8'h04, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[2]  = '{8'h03, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[3]  = '{8'h03, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{8'h03, 8'h02, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{8'h02, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{8'h02, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{8'h02, 8'h00, 8'h02, 3'd1, 1'b1, 1'b0};
        vecs[8]  = '{8'h82, 8'h02, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{8'h82, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{8'h82, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0};
        vecs[11] = '{8'h83, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[12] = '{8'h83, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[13] = '{8'h83, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[14] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[15] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[16] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        req     = 8'hFF;
        fine    = 8'd0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset_low", 8'h00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        apply_stimulus(8'hFF, 8'h00);
        check_all("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        // End one tenure so ptr moves, then reset mid-tenure and confirm ptr returns to 0.
        apply_stimulus(8'hFF, 8'h01);
        apply_stimulus(8'hFF, 8'h00);
        apply_stimulus(8'hFF, 8'h00);
        check_all("second_grant", 8'h02, 3'd1, 1'b1, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all("async_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        apply_stimulus(8'hFF, 8'h00);
        check_all("ptr_reset", 8'h01, 3'd0, 1'b1, 1'b0);

        do_reset(8'h00);
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].fine);
            check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].alpha,
                      vecs[i].busy, vecs[i].timeout);
        end

        do_reset(8'h00);
        for (int n = 0; n < 9; n++) begin
            automatic logic [2:0] k = 3'(n % 8);
            automatic logic [7:0] one = 8'd1 << k;
            apply_stimulus(8'hFF, 8'h00);
            check_all($sformatf("rr%0d_grant", n), one, k, 1'b1, 1'b0);
            apply_stimulus(8'hFF, 8'h00);
            apply_stimulus(8'hFF, one);
            check_all($sformatf("rr%0d_release", n), 8'h00, k, 1'b0, 1'b0);
            apply_stimulus(8'hFF, 8'h00);
            check_output($sformatf("rr%0d_gap", n), grant, 8'h00);
        end

        do_reset(8'h00);
        apply_stimulus(8'h20, 8'h00);
        check_all("to_grant", 8'h20, 3'd5, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            apply_stimulus(8'h20, 8'h00);
            check_all($sformatf("to_hold%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
        end
        apply_stimulus(8'h20, 8'h00);
        check_all("to_pulse", 8'h00, 3'd5, 1'b0, 1'b1);
        apply_stimulus(8'h20, 8'h00);
        check_all("to_clear", 8'h00, 3'd5, 1'b0, 1'b0);

        // Regrant of 5 after wrap; fine[3] must be ignored, fine[5] at the limit suppresses timeout.
        apply_stimulus(8'h20, 8'h00);
        check_all("sim_grant", 8'h20, 3'd5, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            apply_stimulus(8'h28, 8'h08);
            check_output($sformatf("sim_ignore%0d", c), grant, 8'h20);
        end
        apply_stimulus(8'h20, 8'h20);
        check_all("sim_end", 8'h00, 3'd5, 1'b0, 1'b0);
        apply_stimulus(8'h00, 8'h00);
        check_all("sim_after", 8'h00, 3'd5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
